// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the parametrised decimal timer:
//   state_t    - timer control states (IDLE, RUN, PAUSE, DONE)
//   BCD_W      - bits per decimal digit
//   SEG_W      - segments per seven-segment digit
//   SEG_TABLE  - active-low {g..a} patterns for 0..9, entry SEG_BLANK is blank
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int BCD_W     = 4;
    localparam int SEG_W     = 7;
    localparam int SEG_BLANK = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [SEG_W-1:0] SEG_TABLE [0:10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b1111111   // blank
    };

endpackage

// File: rtl/bcd_to_seven_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seven_seg
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   bcd_i  in   BCD_W  digit value; codes above 9 show a blank digit
//   seg_o  out  SEG_W  active-low segments {g..a}
// -----------------------------------------------------------------------------
module bcd_to_seven_seg
    import timer_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[SEG_BLANK];
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/param_hex_timer.sv
// -----------------------------------------------------------------------------
// param_hex_timer
// Parametrised decimal up/down timer driving a bank of seven-segment digits.
// A prescaler divides the clock down to TICK_HZ; each tick increments or
// decrements a NUM_DIGITS-wide BCD count. Supports preset load, clear,
// pause/resume with partial-tick retention and terminal-count detection.
//
// Optional feature (compile-time macro LAP_HOLD_EN): lap hold. When defined,
// a rising edge on lap captures the live count and the display shows that
// capture while lap stays high. When undefined, lap is ignored.
//
// Ports:
//   clock       in   1               system clock
//   reset       in   1               synchronous active-high reset
//   enable      in   1               1 = count on ticks, 0 = pause
//   count_down  in   1               0 = count up, 1 = count down
//   clear       in   1               pulse: zero digits and prescaler, go IDLE
//   load        in   1               pulse: load load_value (nibbles > 9 -> 9)
//   load_value  in   4*NUM_DIGITS    BCD preset, digit 0 in [3:0]
//   lap         in   1               lap hold level (LAP_HOLD_EN only)
//   bcd_out     out  4*NUM_DIGITS    current count, digit 0 least significant
//   hex_out     out  7*NUM_DIGITS    active-low segments, digit 0 in [6:0]
//   running     out  1               high while in RUN
//   wrapped     out  1               pulse when an up count wraps all-9 -> 0
//   expired     out  1               pulse when a down count hits terminal
// -----------------------------------------------------------------------------
module param_hex_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 100,
    parameter int NUM_DIGITS = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        count_down,
    input  logic                        clear,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    input  logic                        lap,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd_out,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out,
    output logic                        running,
    output logic                        wrapped,
    output logic                        expired
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = BCD_W * NUM_DIGITS;
    localparam int SW  = SEG_W * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic [SW-1:0]   hex_q;
    logic            running_q, wrapped_q, expired_q;

    logic [DW-1:0]   inc_val, dec_val, sat_val, disp;
    logic [SW-1:0]   seg_w;
    logic            advance, tick, tick_eff, all_zero, all_nine;
    logic            wrap_ev, expire_ev;

    // The prescaler only advances while running with enable high, so a pause
    // (or enable dropping on the terminal prescaler count) never loses a tick.
    assign advance  = (state_q == RUN) && enable;
    assign tick     = advance && (presc_q == PRESC_MAX);
    // clear and load take precedence; a coinciding tick is dropped.
    assign tick_eff = tick && !clear && !load;

    assign all_zero = (digits_q == '0);
    assign all_nine = (digits_q == {NUM_DIGITS{4'd9}});

    assign wrap_ev   = tick_eff && !count_down && all_nine;
    assign expire_ev = tick_eff &&  count_down && all_zero;

    // Ripple-carry BCD increment/decrement and load saturation.
    always_comb begin
        logic carry, borrow;
        logic [BCD_W-1:0] nib;
        inc_val = digits_q;
        dec_val = digits_q;
        sat_val = load_value;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = digits_q[i*BCD_W +: BCD_W];
            if (carry) begin
                if (nib == 4'd9) begin
                    inc_val[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    inc_val[i*BCD_W +: BCD_W] = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (nib == 4'd0) begin
                    dec_val[i*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    dec_val[i*BCD_W +: BCD_W] = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_value[i*BCD_W +: BCD_W] > 4'd9) begin
                sat_val[i*BCD_W +: BCD_W] = 4'd9;
            end
        end
    end

    always_comb begin
        digits_d = digits_q;
        if (clear) begin
            digits_d = '0;
        end else if (load) begin
            digits_d = sat_val;
        end else if (tick_eff) begin
            if (!count_down) begin
                digits_d = inc_val;
            end else if (!all_zero) begin
                digits_d = dec_val;
            end
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clear || load) begin
            presc_d = '0;
        end else if (advance) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN: begin
                    if (expire_ev)    state_d = DONE;
                    else if (!enable) state_d = PAUSE;
                end
                PAUSE:   if (enable) state_d = RUN;
                DONE:    if (load)   state_d = enable ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            wrapped_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            wrapped_q <= wrap_ev;
            expired_q <= expire_ev;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q  <= '0;
            digits_q <= '0;
        end else begin
            presc_q  <= presc_d;
            digits_q <= digits_d;
        end
    end

`ifdef LAP_HOLD_EN
    logic          lap_prev_q;
    logic [DW-1:0] lap_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lap_prev_q <= 1'b0;
            lap_q      <= '0;
        end else begin
            lap_prev_q <= lap;
            if (clear) begin
                lap_q <= '0;
            end else if (lap && !lap_prev_q) begin
                lap_q <= digits_q;
            end
        end
    end

    // On the rising-edge cycle the capture is not yet in lap_q, so show the
    // live value, which is exactly what is being captured.
    assign disp = (lap && lap_prev_q) ? lap_q : digits_q;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign disp       = digits_q;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        bcd_to_seven_seg u_seg (
            .bcd_i (disp[g*BCD_W +: BCD_W]),
            .seg_o (seg_w[g*SEG_W +: SEG_W])
        );
    end

    // Display register: one cycle behind bcd_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_q <= {NUM_DIGITS{SEG_TABLE[0]}};
        end else begin
            hex_q <= seg_w;
        end
    end

    assign bcd_out = digits_q;
    assign hex_out = hex_q;
    assign running = running_q;
    assign wrapped = wrapped_q;
    assign expired = expired_q;

endmodule
